// File: rtl/if_id_reg.sv
// IF/ID pipeline register: two-entry skid buffer between fetch and decode, with field decode.
// Optional build macro IFID_STALL_CNT_EN adds a saturating decode-stall counter output.

module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm_16,
`ifdef IFID_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        zext_sel
);

  logic        main_valid_q, main_valid_d;
  logic [31:0] main_pc_q, main_pc_d;
  logic [31:0] main_inst_q, main_inst_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  logic accept;
  logic consume;

  // in_ready is the registered "skid empty" flag, so it never sees out_ready combinationally.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign consume  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        // Skid is older than anything offered; a full skid also blocks acceptance.
        main_pc_d    = skid_pc_q;
        main_inst_d  = skid_inst_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_pc_d   = in_pc;
        main_inst_d = in_inst;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = in_pc;
        skid_inst_d  = in_inst;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_pc_d    = in_pc;
      main_inst_d  = in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= 32'h0;
      main_inst_q  <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_inst_q  <= 32'h0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  always_comb begin
    out_valid = main_valid_q;
    out_pc    = main_valid_q ? main_pc_q : 32'h0;
    out_inst  = main_valid_q ? main_inst_q : NOP_INST;
  end

  always_comb begin
    opcode   = out_inst[31:26];
    rs       = out_inst[25:21];
    rt       = out_inst[20:16];
    rd       = out_inst[15:11];
    shamt    = out_inst[10:6];
    funct    = out_inst[5:0];
    imm_16   = out_inst[15:0];
    // andi / ori / xori take a zero-extended immediate
    zext_sel = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
  end

`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Randomized and directed bench for if_id_reg against a two-slot FIFO reference model.
// Counter checks are compiled in when IFID_STALL_CNT_EN is defined.

module tb_if_id_reg;

  localparam logic [31:0] Nop = 32'h0000_0021;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm_16;
  logic        zext_sel;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  if_id_reg #(
    .NOP_INST(Nop)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm_16   (imm_16),
`ifdef IFID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .zext_sel (zext_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: FIFO of {pc, inst}, capacity 2, front is what decode sees.
  logic [63:0] mq[$];
  int          exp_stall = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] epc;
    logic [31:0] einst;
    int          eop;
    if (mq.size() > 0) begin
      epc   = mq[0][63:32];
      einst = mq[0][31:0];
    end else begin
      epc   = 32'h0;
      einst = Nop;
    end
    eop = int'(einst / 32'h0400_0000);
    check_eq("out_valid", {31'b0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    check_eq("in_ready", {31'b0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
    check_eq("out_pc", out_pc, epc);
    check_eq("out_inst", out_inst, einst);
    check_eq("opcode", {26'b0, opcode}, 32'(eop));
    check_eq("rs", {27'b0, rs}, (einst / 32'h20_0000) % 32);
    check_eq("rt", {27'b0, rt}, (einst / 32'h1_0000) % 32);
    check_eq("rd", {27'b0, rd}, (einst / 32'h800) % 32);
    check_eq("shamt", {27'b0, shamt}, (einst / 32'h40) % 32);
    check_eq("funct", {26'b0, funct}, einst % 64);
    check_eq("imm_16", {16'b0, imm_16}, einst % 65536);
    check_eq("zext_sel", {31'b0, zext_sel}, (eop >= 12 && eop <= 14) ? 32'd1 : 32'd0);
`ifdef IFID_STALL_CNT_EN
    check_eq("stall_cnt", {16'b0, stall_cnt}, 32'(exp_stall));
`endif
  endtask

  // Called at a falling edge: drive one cycle, advance the model, check at the next falling edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic fl, input logic ordy);
    int sz;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    flush     = fl;
    out_ready = ordy;
    sz = mq.size();
    if (sz > 0 && !ordy && exp_stall < 65535) exp_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (ordy && sz > 0) void'(mq.pop_front());
      if (v && sz < 2) mq.push_back({pc, inst});
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[31:26] = 6'(12 + $urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_inst   = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // Streaming with no bubbles
    step(1, 32'h0, 32'h1111_0000, 0, 1);
    check_eq("stream0", out_pc, 32'h0);
    step(1, 32'h4, 32'h1111_0004, 0, 1);
    check_eq("stream4", out_pc, 32'h4);
    step(1, 32'h8, 32'h1111_0008, 0, 1);
    check_eq("stream8", out_pc, 32'h8);
    step(0, 32'h0, 32'h0, 0, 1);

    // Backpressure then release
    step(1, 32'h0, 32'h2222_0000, 0, 0);
    step(1, 32'h4, 32'h2222_0004, 0, 0);
    check_eq("bp_hold", out_pc, 32'h0);
    check_eq("bp_ready", {31'b0, in_ready}, 32'd0);
    step(1, 32'h8, 32'h2222_0008, 0, 0);
    check_eq("bp_full", out_pc, 32'h0);
    step(0, 32'h0, 32'h0, 0, 1);
    check_eq("bp_rel4", out_pc, 32'h4);
    step(0, 32'h0, 32'h0, 0, 1);
    check_eq("bp_empty", {31'b0, out_valid}, 32'd0);

    // Field decode
    step(1, 32'h40, 32'h3422_ABCD, 0, 1);
    check_eq("ori_op", {26'b0, opcode}, 32'h0D);
    check_eq("ori_rs", {27'b0, rs}, 32'd1);
    check_eq("ori_rt", {27'b0, rt}, 32'd2);
    check_eq("ori_imm", {16'b0, imm_16}, 32'hABCD);
    check_eq("ori_zext", {31'b0, zext_sel}, 32'd1);
    step(1, 32'h44, 32'h2022_FFFF, 0, 1);
    check_eq("addi_zext", {31'b0, zext_sel}, 32'd0);

    // Flush with both entries full plus a same-cycle offer
    step(1, 32'h100, 32'h3333_0100, 0, 0);
    step(1, 32'h104, 32'h3333_0104, 0, 0);
    step(1, 32'h108, 32'h3333_0108, 1, 0);
    check_eq("fl_valid", {31'b0, out_valid}, 32'd0);
    check_eq("fl_ready", {31'b0, in_ready}, 32'd1);
    check_eq("fl_inst", out_inst, Nop);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 0, 1);

    // Async reset mid-cycle with both entries full
    step(1, 32'h200, 32'h4444_0200, 0, 0);
    step(1, 32'h204, 32'h4444_0204, 0, 0);
    #2;
    rst_n = 1'b0;
    mq.delete();
    exp_stall = 0;
    #1;
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_inst", out_inst, Nop);
    check_eq("rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 32'h0, 32'h0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_inst(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

`ifdef IFID_STALL_CNT_EN
    step(1, 32'h300, 32'h5555_0300, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 32'h0, 32'h0, 0, 0);
    check_eq("cnt_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);
    step(0, 32'h0, 32'h0, 1, 0);
    check_eq("cnt_flush", {16'b0, stall_cnt}, 32'h0000_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
